// File: rtl/clks_alot_generator.sv
// Transmit-side clock synthesiser: programmable high/low phase lengths, edge/pre-edge strobes,
// and an optional phase-preserving pin pause enabled by defining CLKS_ALOT_GEN_PAUSE_EN.
module clks_alot_generator #(
    parameter int RATE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  generation_en_i,
    input  logic                  starting_polarity_i,
    input  logic [RATE_WIDTH-1:0] high_rate_i,
    input  logic [RATE_WIDTH-1:0] low_rate_i,
    output logic                  busy_o,
    output logic                  io_clk_o,
    output logic                  unpausable_level_o,
    output logic                  unpausable_rise_o,
    output logic                  unpausable_fall_o,
    output logic                  unpausable_pre_rise_o,
    output logic                  unpausable_pre_fall_o,
    output logic                  pausable_rise_o,
    output logic                  pausable_fall_o,
    output logic                  pausable_pre_rise_o,
    output logic                  pausable_pre_fall_o,
    input  logic                  pause_en_i,
    input  logic                  pause_polarity_i,
    output logic                  pause_start_violation_o,
    output logic                  pause_stop_violation_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [RATE_WIDTH-1:0] cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  start_q, start_d;
    logic                  tail_q, tail_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    logic                  edge_now;
    logic                  new_level;
    logic                  stop_edge;
    logic [RATE_WIDTH-1:0] rate_sel;
    logic [RATE_WIDTH-1:0] load_val;

    // A programmed rate of 0 behaves exactly like 1: one cycle per phase.
    assign new_level = (state_q == IDLE) ? ~starting_polarity_i : ~level_q;
    assign edge_now  = (state_q == IDLE) ? generation_en_i : (cnt_q == '0);
    assign stop_edge = (state_q == ACTIVE) && (cnt_q == '0) && !generation_en_i
                       && (new_level == start_q);
    assign rate_sel  = new_level ? high_rate_i : low_rate_i;
    assign load_val  = (rate_sel == '0) ? '0 : rate_sel - RATE_WIDTH'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        start_d = start_q;
        tail_d  = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                level_d = starting_polarity_i;
                start_d = starting_polarity_i;
                if (generation_en_i) begin
                    state_d = ACTIVE;
                    level_d = new_level;
                    cnt_d   = load_val;
                    rise_d  = new_level;
                    fall_d  = ~new_level;
                end
            end
            ACTIVE: begin
                if (cnt_q == '0) begin
                    level_d = new_level;
                    cnt_d   = load_val;
                    rise_d  = new_level;
                    fall_d  = ~new_level;
                    if (stop_edge) begin
                        state_d = IDLE;
                        tail_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - RATE_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            start_q <= 1'b0;
            tail_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            start_q <= start_d;
            tail_q  <= tail_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign busy_o                = (state_q == ACTIVE) || tail_q;
    assign unpausable_level_o    = level_q;
    assign unpausable_rise_o     = rise_q;
    assign unpausable_fall_o     = fall_q;
    assign unpausable_pre_rise_o = edge_now && new_level;
    assign unpausable_pre_fall_o = edge_now && !new_level;

`ifdef CLKS_ALOT_GEN_PAUSE_EN
    logic io_q, io_d;
    logic paused_q, paused_d;
    logic ppol_q, ppol_d;
    logic pen_q;
    logic prise_q, pfall_q;
    logic sv_start_q, sv_stop_q;
    logic pin_pre_rise, pin_pre_fall;

    always_comb begin
        io_d     = io_q;
        paused_d = paused_q;
        ppol_d   = ppol_q;
        if (state_q == IDLE) begin
            io_d     = level_d;
            paused_d = 1'b0;
        end else if (edge_now) begin
            if (stop_edge) begin
                io_d     = new_level;
                paused_d = 1'b0;
            end else if (paused_q) begin
                // Release only on an edge into the held level, so the pin rejoins in phase.
                if (!pause_en_i && (new_level == ppol_q)) begin
                    io_d     = new_level;
                    paused_d = 1'b0;
                end
            end else begin
                io_d = new_level;
                if (pause_en_i && (new_level == pause_polarity_i)) begin
                    paused_d = 1'b1;
                    ppol_d   = pause_polarity_i;
                end
            end
        end
    end

    assign pin_pre_rise = edge_now && io_d && !io_q;
    assign pin_pre_fall = edge_now && !io_d && io_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_q       <= 1'b0;
            paused_q   <= 1'b0;
            ppol_q     <= 1'b0;
            pen_q      <= 1'b0;
            prise_q    <= 1'b0;
            pfall_q    <= 1'b0;
            sv_start_q <= 1'b0;
            sv_stop_q  <= 1'b0;
        end else begin
            io_q       <= io_d;
            paused_q   <= paused_d;
            ppol_q     <= ppol_d;
            pen_q      <= pause_en_i;
            prise_q    <= pin_pre_rise;
            pfall_q    <= pin_pre_fall;
            sv_start_q <= pause_en_i && !pen_q && (state_q == IDLE);
            sv_stop_q  <= !pause_en_i && pen_q && (state_q == ACTIVE) && !paused_q;
        end
    end

    assign io_clk_o                = io_q;
    assign pausable_rise_o         = prise_q;
    assign pausable_fall_o         = pfall_q;
    assign pausable_pre_rise_o     = pin_pre_rise;
    assign pausable_pre_fall_o     = pin_pre_fall;
    assign pause_start_violation_o = sv_start_q;
    assign pause_stop_violation_o  = sv_stop_q;
`else
    logic unused_pause;
    assign unused_pause = pause_en_i ^ pause_polarity_i;

    assign io_clk_o                = level_q;
    assign pausable_rise_o         = rise_q;
    assign pausable_fall_o         = fall_q;
    assign pausable_pre_rise_o     = unpausable_pre_rise_o;
    assign pausable_pre_fall_o     = unpausable_pre_fall_o;
    assign pause_start_violation_o = 1'b0;
    assign pause_stop_violation_o  = 1'b0;
`endif

endmodule
